// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer between the program ROM and alu_mod.
// Fetches a word, decodes it, issues ALU operations with a valid/ready
// handshake and executes control opcodes (NOP/JMP/CALL/RET/HALT) locally,
// keeping return addresses on a small private stack.
module alu_seq_ctrl #(
    parameter int WIDTH       = 8,
    parameter int IWIDTH      = 8,
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4,
    parameter int INSTR_W     = IWIDTH + 6 + 3 * WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               alu_ready,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic [IWIDTH-1:0]  op_code,
    output logic [WIDTH-1:0]   source1,
    output logic [WIDTH-1:0]   source2,
    output logic [1:0]         source1_choice,
    output logic [1:0]         source2_choice,
    output logic [WIDTH-1:0]   destination,
    output logic [1:0]         dest_choice,
    output logic               alu_en,
    output logic               push,
    output logic               pop,
    output logic               busy,
    output logic               halted,
    output logic               error
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int FLD  = 3 * WIDTH;

    localparam logic [IWIDTH-1:0] OP_NOP  = IWIDTH'(8'hF0);
    localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'(8'hF1);
    localparam logic [IWIDTH-1:0] OP_CALL = IWIDTH'(8'hF2);
    localparam logic [IWIDTH-1:0] OP_RET  = IWIDTH'(8'hF3);
    localparam logic [IWIDTH-1:0] OP_HALT = IWIDTH'(8'hFF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    // Only the opcode and the jump/call target are needed after decode.
    logic [IWIDTH-1:0] ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_tgt_q, ir_tgt_d;

    logic [IWIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0]  src1_q, src1_d;
    logic [WIDTH-1:0]  src2_q, src2_d;
    logic [WIDTH-1:0]  dst_q, dst_d;
    logic [1:0]        s1ch_q, s1ch_d;
    logic [1:0]        s2ch_q, s2ch_d;
    logic [1:0]        dch_q, dch_d;
    logic              alu_en_q, alu_en_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;

    logic              stack_we;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] stack_rd [STACK_DEPTH];
    logic              stack_full;
    logic              stack_empty;

    // Fields of the word currently on the ROM bus (valid in DECODE).
    logic [IWIDTH-1:0] dec_op;
    logic [1:0]        dec_s1ch, dec_s2ch, dec_dch;
    logic [WIDTH-1:0]  dec_src1, dec_src2, dec_dst;
    logic              dec_is_ctrl;

    assign dec_op   = instr_data[INSTR_W-1 -: IWIDTH];
    assign dec_s1ch = instr_data[FLD+5 -: 2];
    assign dec_s2ch = instr_data[FLD+3 -: 2];
    assign dec_dch  = instr_data[FLD+1 -: 2];
    assign dec_src1 = instr_data[3*WIDTH-1 -: WIDTH];
    assign dec_src2 = instr_data[2*WIDTH-1 -: WIDTH];
    assign dec_dst  = instr_data[WIDTH-1:0];

    assign dec_is_ctrl = (dec_op == OP_NOP) || (dec_op == OP_JMP) ||
                         (dec_op == OP_CALL) || (dec_op == OP_RET) ||
                         (dec_op == OP_HALT);

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Return-address stack: one register per slot, written when it is the top.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            logic [ADDR_W-1:0] entry_q;
            // Capture PC+1 into this slot on a CALL while it is the free top entry.
            always_ff @(posedge clk) begin
                if (!rst && stack_we && (sp_q == SP_W'(gi))) begin
                    entry_q <= pc_inc;
                end
            end
            assign stack_rd[gi] = entry_q;
        end
    endgenerate

    // Select the entry just below the stack pointer for RET.
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                ret_addr = stack_rd[i];
            end
        end
    end

    // Next-state, PC/stack and output-register logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        ir_op_d  = ir_op_q;
        ir_tgt_d = ir_tgt_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        s1ch_d   = s1ch_q;
        s2ch_d   = s2ch_q;
        dch_d    = dch_q;
        alu_en_d = alu_en_q;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        stack_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    sp_d    = '0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_op_d  = dec_op;
                ir_tgt_d = dec_dst[ADDR_W-1:0];
                state_d  = S_EXEC;
                if (!dec_is_ctrl) begin
                    // ALU op: fields and strobe become visible on entry to EXEC.
                    op_d     = dec_op;
                    src1_d   = dec_src1;
                    src2_d   = dec_src2;
                    dst_d    = dec_dst;
                    s1ch_d   = dec_s1ch;
                    s2ch_d   = dec_s2ch;
                    dch_d    = dec_dch;
                    alu_en_d = 1'b1;
                end else if (dec_op == OP_CALL && !stack_full) begin
                    push_d = 1'b1;
                end else if (dec_op == OP_RET && !stack_empty) begin
                    pop_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (ir_op_q)
                    OP_NOP: begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = ir_tgt_q;
                        state_d = S_FETCH;
                    end
                    OP_CALL: begin
                        if (stack_full) begin
                            state_d = S_ERROR;
                        end else begin
                            stack_we = 1'b1;
                            sp_d     = sp_q + SP_W'(1);
                            pc_d     = ir_tgt_q;
                            state_d  = S_FETCH;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            state_d = S_ERROR;
                        end else begin
                            sp_d    = sp_q - SP_W'(1);
                            pc_d    = ret_addr;
                            state_d = S_FETCH;
                        end
                    end
                    OP_HALT: begin
                        state_d = S_HALTED;
                    end
                    default: begin
                        if (alu_ready) begin
                            pc_d     = pc_inc;
                            alu_en_d = 1'b0;
                            state_d  = S_FETCH;
                        end
                    end
                endcase
            end
            S_HALTED, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    sp_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALTED);
        error_d  = (state_d == S_ERROR);
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            sp_q     <= '0;
            ir_op_q  <= '0;
            ir_tgt_q <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            s1ch_q   <= '0;
            s2ch_q   <= '0;
            dch_q    <= '0;
            alu_en_q <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            ir_op_q  <= ir_op_d;
            ir_tgt_q <= ir_tgt_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            s1ch_q   <= s1ch_d;
            s2ch_q   <= s2ch_d;
            dch_q    <= dch_d;
            alu_en_q <= alu_en_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    assign instr_addr     = pc_q;
    assign op_code        = op_q;
    assign source1        = src1_q;
    assign source2        = src2_q;
    assign destination    = dst_q;
    assign source1_choice = s1ch_q;
    assign source2_choice = s2ch_q;
    assign dest_choice    = dch_q;
    assign alu_en         = alu_en_q;
    assign push           = push_q;
    assign pop            = pop_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign error          = error_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed timing scenarios followed by random
// programs compared against an instruction-level interpreter.
module tb_alu_seq_ctrl;

    localparam int IW = 38;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          alu_ready = 1'b0;
    logic [IW-1:0] instr_data;
    logic [5:0]    instr_addr;
    logic [7:0]    op_code, source1, source2, destination;
    logic [1:0]    source1_choice, source2_choice, dest_choice;
    logic          alu_en, push, pop, busy, halted, error;

    logic [IW-1:0] rom [64];

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .instr_data(instr_data),
        .alu_ready(alu_ready), .instr_addr(instr_addr), .op_code(op_code),
        .source1(source1), .source2(source2),
        .source1_choice(source1_choice), .source2_choice(source2_choice),
        .destination(destination), .dest_choice(dest_choice),
        .alu_en(alu_en), .push(push), .pop(pop), .busy(busy),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address.
    always @(posedge clk) instr_data <= rom[instr_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [7:0] op, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] c,
                                         input logic [7:0] s1, input logic [7:0] s2,
                                         input logic [7:0] d);
        return {op, a, b, c, s1, s2, d};
    endfunction

    function automatic logic [IW-1:0] fields();
        return {op_code, source1_choice, source2_choice, dest_choice, source1, source2, destination};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mk(8'hFF, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] got_q[$];
    int exp_push, exp_pop, exp_status, exp_pc;
    int n_push, n_pop;

    task automatic model_run();
        int pc;
        int stk[$];
        logic [IW-1:0] w;
        logic [7:0] op;
        pc = 0;
        exp_q.delete();
        exp_push = 0;
        exp_pop = 0;
        exp_status = 0;
        for (int steps = 0; steps < 300 && exp_status == 0; steps++) begin
            w  = rom[pc];
            op = w[37:30];
            case (op)
                8'hF0: pc = (pc + 1) % 64;
                8'hF1: pc = int'(w[7:0]) % 64;
                8'hF2: begin
                    if (stk.size() == 4) exp_status = 2;
                    else begin
                        stk.push_back((pc + 1) % 64);
                        exp_push++;
                        pc = int'(w[7:0]) % 64;
                    end
                end
                8'hF3: begin
                    if (stk.size() == 0) exp_status = 2;
                    else begin
                        pc = stk.pop_back();
                        exp_pop++;
                    end
                end
                8'hFF: exp_status = 1;
                default: begin
                    exp_q.push_back(w);
                    pc = (pc + 1) % 64;
                end
            endcase
        end
        exp_pc = pc;
    endtask

    task automatic gen_prog();
        int r;
        logic [7:0] op;
        bit ok;
        ok = 0;
        for (int tries = 0; tries < 50 && !ok; tries++) begin
            for (int a = 0; a < 64; a++) begin
                r = $urandom_range(0, 99);
                if (r < 50)      op = 8'($urandom_range(0, 8'hEF));
                else if (r < 60) op = 8'hF0;
                else if (r < 68) op = 8'hF1;
                else if (r < 78) op = 8'hF2;
                else if (r < 88) op = 8'hF3;
                else             op = 8'hFF;
                rom[a] = mk(op, 2'($urandom), 2'($urandom), 2'($urandom),
                            8'($urandom), 8'($urandom), 8'($urandom));
            end
            model_run();
            ok = (exp_status != 0);
        end
        if (!ok) begin
            rom[0] = mk(8'hFF, 0, 0, 0, 0, 0, 0);
            model_run();
        end
    endtask

    // Run from a pending start until halted/error, logging issues and pulses.
    task automatic run_until_done(input int budget, input bit ready_high);
        bit done;
        bit prev_stall;
        logic [IW-1:0] prev_word;
        logic [IW-1:0] cur;
        got_q.delete();
        n_push = 0;
        n_pop = 0;
        done = 0;
        prev_stall = 0;
        prev_word = '0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            start = 1'b0;
            cur = fields();
            if (prev_stall) begin
                check("stall_hold", {alu_en, cur}, {1'b1, prev_word});
            end
            check("status_excl", 64'(int'(busy) + int'(halted) + int'(error) <= 1), 64'd1);
            alu_ready = ready_high ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (push) n_push++;
            if (pop) n_pop++;
            if (alu_en && alu_ready) got_q.push_back(cur);
            prev_stall = alu_en && !alu_ready;
            prev_word = cur;
            if (halted || error) done = 1;
        end
        check("run_done", 64'(done), 64'd1);
    endtask

    task automatic compare_run(input string tag);
        int st;
        st = halted ? 1 : (error ? 2 : 0);
        check({tag, "_nissue"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_issue"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_push"}, 64'(n_push), 64'(exp_push));
        check({tag, "_pop"}, 64'(n_pop), 64'(exp_pop));
        check({tag, "_status"}, 64'(st), 64'(exp_status));
        check({tag, "_pc"}, 64'(instr_addr), 64'(exp_pc));
        $display("run %s: issues=%0d push=%0d pop=%0d status=%0d pc=%0d",
                 tag, got_q.size(), n_push, n_pop, st, instr_addr);
    endtask

    initial begin
        bit en_seen;
        clear_rom();

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_addr", 64'(instr_addr), 64'd0);
        check("rst_fields", 64'(fields()), 64'd0);
        check("rst_flags", {alu_en, push, pop, busy, halted, error}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // 1: single ALU op then HALT, ready tied high
        rom[0] = mk(8'h01, 2'd1, 2'd0, 2'd0, 8'h10, 8'h20, 8'h30);
        rom[1] = mk(8'hFF, 0, 0, 0, 0, 0, 0);
        alu_ready = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_en_c1", 64'(alu_en), 64'd0);
        @(negedge clk);
        check("t1_en_c2", 64'(alu_en), 64'd0);
        @(negedge clk);
        check("t1_en_c3", 64'(alu_en), 64'd1);
        check("t1_fields", 64'(fields()), 64'(rom[0]));
        check("t1_addr", 64'(instr_addr), 64'd0);
        @(negedge clk);
        check("t1_en_drop", 64'(alu_en), 64'd0);
        check("t1_pc_inc", 64'(instr_addr), 64'd1);
        repeat (3) @(negedge clk);
        check("t1_halted", {busy, halted, error}, 64'b010);
        check("t1_final_addr", 64'(instr_addr), 64'd1);
        $display("t1: single issue then HALT done");

        // 2: same program, alu_ready low for four EXEC cycles
        alu_ready = 1'b0;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t2_en_hold", 64'(alu_en), 64'd1);
            check("t2_fields_hold", 64'(fields()), 64'(rom[0]));
            check("t2_pc_hold", 64'(instr_addr), 64'd0);
            if (k == 4) alu_ready = 1'b1;
        end
        @(negedge clk);
        check("t2_en_drop", 64'(alu_en), 64'd0);
        check("t2_pc_inc", 64'(instr_addr), 64'd1);
        repeat (3) @(negedge clk);
        check("t2_halted", 64'(halted), 64'd1);
        $display("t2: stalled issue done");

        // 3: JMP 5, HALT at 5
        clear_rom();
        rom[0] = mk(8'hF1, 0, 0, 0, 0, 0, 8'h05);
        start = 1'b1;
        en_seen = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); start = 1'b0;
            en_seen |= alu_en;
            if (k == 1) check("t3_addr0", 64'(instr_addr), 64'd0);
            if (k == 4) check("t3_addr5", 64'(instr_addr), 64'd5);
        end
        check("t3_halted", {halted, instr_addr}, {1'b1, 6'd5});
        check("t3_no_en", 64'(en_seen), 64'd0);
        $display("t3: JMP done");

        // 4: CALL 8, RET at 8, HALT at 1
        clear_rom();
        rom[0] = mk(8'hF2, 0, 0, 0, 0, 0, 8'h08);
        rom[8] = mk(8'hF3, 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 3) check("t4_push", {push, pop}, 64'b10);
            if (k == 4) check("t4_call_tgt", {push, instr_addr}, {1'b0, 6'd8});
            if (k == 6) check("t4_pop", {push, pop}, 64'b01);
            if (k == 7) check("t4_ret_tgt", {pop, instr_addr}, {1'b0, 6'd1});
        end
        check("t4_halted", {halted, instr_addr}, {1'b1, 6'd1});
        check("t4_last_fields", 64'(fields()), 64'(mk(8'h01, 2'd1, 2'd0, 2'd0, 8'h10, 8'h20, 8'h30)));
        $display("t4: CALL/RET done");

        // 5: five nested CALLs overflow the four-entry stack
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = mk(8'hF2, 0, 0, 0, 0, 0, 8'(i + 1));
        model_run();
        start = 1'b1;
        run_until_done(200, 1'b1);
        compare_run("t5_overflow");
        check("t5_error", {error, halted}, 64'b10);
        // RET on an empty stack, restarted from ERROR
        rom[0] = mk(8'hF3, 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 1) check("t5_restart", {error, busy, instr_addr}, {1'b0, 1'b1, 6'd0});
            if (k == 3) check("t5_no_pop", 64'(pop), 64'd0);
        end
        check("t5_ret_error", {error, instr_addr}, {1'b1, 6'd0});
        $display("t5: stack overflow/underflow done");

        // 6: reset during a stalled EXEC
        clear_rom();
        rom[0] = mk(8'hF0, 0, 0, 0, 0, 0, 0);
        rom[1] = mk(8'h22, 2'd2, 2'd3, 2'd1, 8'h44, 8'h55, 8'h66);
        alu_ready = 1'b0;
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); start = 1'b0;
        end
        check("t6_stalled", {alu_en, instr_addr}, {1'b1, 6'd1});
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_flags", {alu_en, busy, halted, error, push, pop}, 64'd0);
        check("t6_rst_addr", 64'(instr_addr), 64'd0);
        check("t6_rst_fields", 64'(fields()), 64'd0);
        rst = 1'b0;
        // PC wrap: JMP 63, NOP at 63
        rom[0] = mk(8'hF1, 0, 0, 0, 0, 0, 8'h3F);
        rom[63] = mk(8'hF0, 0, 0, 0, 0, 0, 0);
        alu_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 1) check("t6_wrap_a0", 64'(instr_addr), 64'd0);
            if (k == 4) check("t6_wrap_a63", 64'(instr_addr), 64'd63);
            if (k == 7) check("t6_wrap_back", 64'(instr_addr), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("t6: reset and wrap done");

        // Random programs vs the interpreter
        for (int p = 0; p < 12; p++) begin
            gen_prog();
            @(negedge clk);
            start = 1'b1;
            run_until_done(6000, (p % 3) == 0);
            compare_run($sformatf("rand%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Instruction sequencer that fetches words from a synchronous instruction ROM, decodes them and issues ALU operations to alu_mod.
- Drives op_code, source/destination fields and choices, push/pop and instr_addr toward alu_mod.
- Executes control opcodes (NOP, JMP, CALL, RET, HALT) internally, using a private return-address stack.
- Sits between the program ROM and alu_mod in the PLC core.

Parameters:
WIDTH, 8, data/operand address width of source1/source2/destination
IWIDTH, 8, op_code width
ADDR_W, 6, instruction address width
STACK_DEPTH, 4, return-address stack entries
INSTR_W, IWIDTH+6+3*WIDTH (38), instruction word width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  run request; honoured in IDLE, HALTED, ERROR
instr_data  in  INSTR_W  ROM read data, valid 1 cycle after instr_addr
alu_ready  in  1  alu_mod accepts issued operation this cycle
instr_addr  out  ADDR_W  ROM address / PC to alu_mod
op_code  out  IWIDTH  issued opcode
source1  out  WIDTH  operand 1 address
source2  out  WIDTH  operand 2 address
source1_choice  out  2  operand 1 source select
source2_choice  out  2  operand 2 source select
destination  out  WIDTH  result address
dest_choice  out  2  result destination select
alu_en  out  1  issue strobe, held until alu_ready
push  out  1  one-cycle pulse on CALL
pop  out  1  one-cycle pulse on RET
busy  out  1  high in FETCH/DECODE/EXEC
halted  out  1  high in HALTED
error  out  1  high in ERROR

Behaviour:
- Instruction format: [37:30] op, [29:28] s1ch, [27:26] s2ch, [25:24] dch, [23:16] source1, [15:8] source2, [7:0] destination.
- Control opcodes: 8'hF0 NOP, 8'hF1 JMP, 8'hF2 CALL, 8'hF3 RET, 8'hFF HALT. All other values are ALU ops.
- Reset: state IDLE, PC=0, stack pointer=0, IR=0. All outputs are 0.
- FSM transitions:
  - IDLE: start=1 -> FETCH with PC=0.
  - FETCH: instr_addr=PC -> DECODE.
  - DECODE: IR<=instr_data -> EXEC.
  - EXEC: per opcode, below.
- EXEC, ALU op: field outputs are registered from IR on entry to EXEC; alu_en=1. Hold alu_en and fields until alu_ready=1 in EXEC. On that cycle: PC<=PC+1, alu_en drops next cycle -> FETCH. Issue latency is 3 cycles from FETCH with alu_ready tied high.
- EXEC, NOP: PC+1 -> FETCH.
- EXEC, JMP: PC<=destination[ADDR_W-1:0] -> FETCH.
- EXEC, CALL: if stack full -> ERROR. Otherwise stack[sp]<=PC+1, sp+1, PC<=destination[ADDR_W-1:0], push=1 for one cycle -> FETCH.
- EXEC, RET: if stack empty -> ERROR. Otherwise sp-1, PC<=stack[sp-1], pop=1 for one cycle -> FETCH.
- EXEC, HALT: -> HALTED; PC holds.
- Control opcodes do not assert alu_en. Field outputs keep their last-issued values.
- PC increment wraps 2^ADDR_W-1 -> 0.
- HALTED/ERROR: start=1 -> FETCH with PC=0, sp=0; error/halted clear.
- start is ignored while busy.
- rst has priority over every event, including mid-EXEC with alu_en high: next cycle all outputs are 0 and state is IDLE.
- busy/halted/error are mutually exclusive and registered from the state.

Test Plan:
1. ROM[0]=ALU op 8'h01, s1ch=1, src1=8'h10, src2=8'h20, dest=8'h30; ROM[1]=HALT; alu_ready=1; pulse start -> alu_en high one cycle, 3 cycles after start is registered, with op_code=8'h01, source1=8'h10, destination=8'h30; then halted=1 and instr_addr=1.
2. Same program with alu_ready low for 4 cycles -> alu_en and all fields stable for 5 cycles; PC advances only after alu_ready=1.
3. ROM[0]=JMP dest=8'h05; ROM[5]=HALT -> instr_addr sequence 0,5; halted=1; alu_en never asserts.
4. ROM[0]=CALL 8'h08; ROM[8]=RET; ROM[1]=HALT -> push pulse in first EXEC, pop pulse at addr 8; final instr_addr=1 with halted=1.
5. Five nested CALLs with STACK_DEPTH=4 -> error=1 on the fifth CALL, no push pulse for it. RET at ROM[0] -> error=1 immediately. start from ERROR -> restart at 0.
6. rst=1 while in EXEC with alu_ready=0 -> next cycle alu_en=0, busy=0, instr_addr=0, all field outputs 0. JMP to 63 followed by a NOP at 63 -> instr_addr wraps to 0.
